// File: rtl/regfile_fwd_pkg.sv
// Shared types for the register-file forwarding controller: operand select
// encoding, the zero-register index and the pipeline slot record.
package regfile_fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       reg_wrt;
    logic       mem_rd;
    logic [4:0] rd;
  } slot_t;

endpackage

// File: rtl/regfile_fwd_slot.sv
// One in-flight write slot (EX, MEM or WB); cleared to a bubble on reset.
module fwd_slot
  import regfile_fwd_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/regfile_fwd_ctrl.sv
// Decode-side forwarding and load-use stall control; tracks in-flight
// register writes in an EX/MEM/WB slot chain and selects operand sources.
module regfile_fwd_ctrl
  import regfile_fwd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             flush,
  input  logic             RegWrt,
  input  logic             MemRd,
  input  logic [4:0]       Rd,
  input  logic [4:0]       Rn,
  input  logic [4:0]       Rm,
  input  logic             UseRn,
  input  logic             UseRm,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  slot_t ex_d, ex_q, mem_q, wb_q;

  function automatic logic slot_hit(slot_t s, logic [4:0] src, logic use_src);
    return s.reg_wrt && (s.rd == src) && (src != XZR) && use_src;
  endfunction

  // Youngest matching slot wins.
  function automatic fwd_sel_t fwd_pick(slot_t ex, slot_t mem, slot_t wb,
                                        logic [4:0] src, logic use_src);
    if (slot_hit(ex, src, use_src))       return FWD_EX;
    else if (slot_hit(mem, src, use_src)) return FWD_MEM;
    else if (slot_hit(wb, src, use_src))  return FWD_WB;
    else                                  return FWD_RF;
  endfunction

  always_comb begin
    ex_d = '0;
    if (issue_valid && !stall && !flush) begin
      ex_d.reg_wrt = RegWrt;
      ex_d.mem_rd  = MemRd;
      ex_d.rd      = Rd;
    end
  end

  fwd_slot u_ex  (.clk(clk), .reset(reset), .d(ex_d),  .q(ex_q));
  fwd_slot u_mem (.clk(clk), .reset(reset), .d(ex_q),  .q(mem_q));
  fwd_slot u_wb  (.clk(clk), .reset(reset), .d(mem_q), .q(wb_q));

  assign FwdA = fwd_pick(ex_q, mem_q, wb_q, Rn, UseRn);
  assign FwdB = fwd_pick(ex_q, mem_q, wb_q, Rm, UseRm);

  assign stall = issue_valid && !flush && ex_q.mem_rd &&
                 (slot_hit(ex_q, Rn, UseRn) || slot_hit(ex_q, Rm, UseRm));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_regfile_fwd_ctrl.sv
// Scoreboard bench for regfile_fwd_ctrl: each driven cycle queues its expected
// selects/stall/count, which are compared on the following falling edge.
module tb_regfile_fwd_ctrl;

  localparam int CW = 8;
  localparam logic [CW-1:0] MAXC = '1;

  logic          clk;
  logic          reset;
  logic          issue_valid, flush, RegWrt, MemRd, UseRn, UseRm;
  logic [4:0]    Rd, Rn, Rm;
  logic [1:0]    FwdA, FwdB;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [CW-1:0] exp_cnt;

  regfile_fwd_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .flush(flush),
    .RegWrt(RegWrt), .MemRd(MemRd), .Rd(Rd), .Rn(Rn), .Rm(Rm),
    .UseRn(UseRn), .UseRm(UseRm), .FwdA(FwdA), .FwdB(FwdB),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, ".fwd_a"}, 32'(FwdA), 32'(mon_e.fa));
      chk({mon_e.tag, ".fwd_b"}, 32'(FwdB), 32'(mon_e.fb));
      chk({mon_e.tag, ".stall"}, 32'(stall), 32'(mon_e.st));
      chk({mon_e.tag, ".cnt"}, 32'(stall_cnt), 32'(mon_e.cnt));
    end
  end

  task automatic set_in(bit iv, bit fl, bit rw, bit mr, logic [4:0] rd,
                        logic [4:0] rn, logic [4:0] rm, bit un, bit um);
    issue_valid = iv; flush = fl; RegWrt = rw; MemRd = mr;
    Rd = rd; Rn = rn; Rm = rm; UseRn = un; UseRm = um;
  endtask

  // Called just after a rising edge; expectations describe this cycle.
  task automatic cyc(string tag, bit iv, bit fl, bit rw, bit mr, logic [4:0] rd,
                     logic [4:0] rn, logic [4:0] rm, bit un, bit um,
                     logic [1:0] efa, logic [1:0] efb, bit est);
    set_in(iv, fl, rw, mr, rd, rn, rm, un, um);
    sb.push_back('{tag, efa, efb, est, exp_cnt});
    if (est && exp_cnt != MAXC) exp_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    exp_cnt = '0;
    reset = 1'b1;
    set_in(1, 0, 1, 1, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1);
    #1 reset = 1'b0;
    #2;
    chk("rst.fwd_a", 32'(FwdA), 0);
    chk("rst.fwd_b", 32'(FwdB), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.cnt", 32'(stall_cnt), 0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold.cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst.fwd_a", 32'(FwdA), 0);
    chk("post_rst.fwd_b", 32'(FwdB), 0);
    chk("post_rst.stall", 32'(stall), 0);
    chk("post_rst.cnt", 32'(stall_cnt), 0);

    // EX forward, then ageing through MEM and WB
    cyc("ex_issue", 1, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc("ex_fwd",   1, 0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0);
    cyc("mem_fwd",  1, 0, 0, 0, 0, 5, 0, 1, 0, 2, 0, 0);
    cyc("wb_fwd",   1, 0, 0, 0, 0, 5, 0, 1, 0, 3, 0, 0);
    cyc("gone",     1, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    idle(3);

    // Priority: youngest slot wins
    cyc("p_i1",  1, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc("p_i2",  1, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc("p_rm",  1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 0);
    idle(3);
    cyc("p_i3",  1, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc("p_both", 1, 0, 0, 0, 0, 7, 7, 1, 1, 1, 1, 0);
    cyc("p_both_mem", 1, 0, 0, 0, 0, 7, 7, 1, 1, 2, 2, 0);
    idle(3);

    // XZR and Use gating
    cyc("x_i31", 1, 0, 1, 0, 31, 0, 0, 0, 0, 0, 0, 0);
    cyc("x_rd31", 1, 0, 0, 0, 0, 31, 31, 1, 1, 0, 0, 0);
    cyc("u_i3",  1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc("u_gate", 1, 0, 0, 0, 0, 3, 3, 1, 0, 1, 0, 0);
    idle(3);

    // Load-use: one stall, then MEM forward
    cyc("lu_ld",    1, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    cyc("lu_stall", 1, 0, 0, 0, 0, 9, 0, 1, 0, 1, 0, 1);
    cyc("lu_go",    1, 0, 0, 0, 0, 9, 0, 1, 0, 2, 0, 0);
    chk("lu.cnt_one", 32'(stall_cnt), 1);
    idle(3);

    // Flush beats stall; the flushed writer never appears
    cyc("fl_ld",  1, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    cyc("fl_sq",  1, 1, 1, 0, 12, 10, 0, 1, 0, 1, 0, 0);
    cyc("fl_chk", 1, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, 0);
    cyc("fl_chk2", 1, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, 0);
    idle(3);

    // Back-to-back dependent loads until the counter saturates
    cyc("bb_ld0", 1, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc("bb_stall", 1, 0, 1, 1, 9, 9, 0, 1, 0, 1, 0, 1);
      cyc("bb_go",    1, 0, 1, 1, 9, 9, 0, 1, 0, 2, 0, 0);
    end
    chk("cnt_sat", 32'(stall_cnt), 32'(MAXC));

    // Reset asserted in the middle of a stall cycle
    set_in(1, 0, 1, 1, 9, 9, 0, 1, 0);
    #1 chk("pre_rst.stall", 32'(stall), 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst.stall", 32'(stall), 0);
    chk("mid_rst.fwd_a", 32'(FwdA), 0);
    chk("mid_rst.cnt", 32'(stall_cnt), 0);
    exp_cnt = '0;
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    cyc("ar_ld",    1, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    cyc("ar_stall", 1, 0, 0, 0, 0, 0, 9, 0, 1, 0, 1, 1);
    cyc("ar_go",    1, 0, 0, 0, 0, 0, 9, 0, 1, 0, 2, 0);

    if (sb.size() != 0) chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_fwd_ctrl.md
# regfile_fwd_ctrl

Reader-side counterpart to the register-file write queue. The block tracks every in-flight register write across the EX, MEM and WB stages and checks each decoded instruction's source registers against them. It produces forwarding selects for both operand buses, a one-cycle load-use stall, and a saturating stall-cycle counter. It sits beside the decode stage and drives the operand muxes at the ID/EX boundary.

## Interface
Parameters:
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately
- issue_valid  in  1  decode stage holds a real instruction
- flush  in  1  squash the decode-stage instruction (taken branch); it enters EX as a bubble
- RegWrt  in  1  decoded instruction writes the register file
- MemRd  in  1  decoded instruction is a load
- Rd  in  5  decoded destination register
- Rn  in  5  decoded source A
- Rm  in  5  decoded source B
- UseRn  in  1  source A is actually read
- UseRm  in  1  source B is actually read
- FwdA  out  2  operand-A select: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
- FwdB  out  2  operand-B select, same encoding
- stall  out  1  hold PC and IF/ID; insert a bubble into EX
- stall_cnt  out  CNT_W  count of cycles with stall=1, saturating

## Operation
- Three slots, EX, MEM and WB, each hold {RegWrt, MemRd, Rd}. A slot whose RegWrt=0 is a bubble.
- Every clock, slots shift: WB←MEM, MEM←EX.
- EX loads {RegWrt, MemRd, Rd} when issue_valid & ~stall & ~flush. Otherwise EX loads a bubble (all zero).
- A slot matches source S when the slot's RegWrt=1, its Rd==S, S≠31 (XZR is never forwarded), and the corresponding Use bit is 1.
- Fwd priority, youngest first:
  - EX match → 1
  - else MEM match → 2
  - else WB match → 3
  - else 0
- Load-use rule: stall=1 when issue_valid & ~flush and the EX slot has MemRd=1 and matches Rn (with UseRn) or Rm (with UseRm).
- While stall=1:
  - FwdA and FwdB are still computed but are don't-care downstream.
  - Upstream holds Rd, Rn, Rm and the flags stable.
- The next cycle, the load has moved to MEM, so the check re-evaluates and returns Fwd=2.
- flush has priority over stall: flush=1 forces stall=0.
- stall_cnt increments on every clock edge where stall=1 and saturates at 2^CNT_W−1.
- Outputs FwdA, FwdB and stall are combinational from the slots and the current inputs. No other logic sits between the slot flops and these outputs.

## Timing
- Reset values:
  - all slots are bubbles, so FwdA=FwdB=0 and stall=0
  - stall_cnt=0
- Reset asserted mid-operation: every slot clears asynchronously, and outputs go to reset values in the same cycle.
- Latency: an instruction accepted at edge k occupies EX during cycle k, MEM during k+1 and WB during k+2. It is gone after edge k+3, which matches the 3-cycle write queue.
- Same-cycle dependency: Rn equal to an instruction issuing this cycle is invisible until next cycle, because EX is updated at the edge.
- A load-use hazard costs exactly one stall cycle. Back-to-back dependent loads cost one stall each.
- Simultaneous matches in several slots resolve to the youngest slot.
- A match on both Rn and Rm sets both selects independently.
- A WB match is still forwarded, because the regfile write completes only at the end of WB.

## Structure
- Package regfile_fwd_pkg holds:
  - fwd_sel_t encoding (FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3)
  - XZR constant 5'd31
  - slot struct {RegWrt, MemRd, Rd}
- Sub-module fwd_slot: one slot register with async active-low clear. Instantiate it three times as a chain, mirroring the write-queue stages.
- Compare and priority logic lives in the top module as a function applied to each source.

## Test plan
- Reset check: reset=0 with arbitrary inputs → FwdA=FwdB=0, stall=0, stall_cnt=0. After release and 3 idle cycles, outputs are unchanged.
- EX forward: issue ADD Rd=5, then next cycle Rn=5 → FwdA=1. In the following cycles with the same Rn held → FwdA=2, then 3, then 0.
- Priority: issue Rd=7, then Rd=7 again, then Rm=7 → FwdB=1, not 2. Rn=Rm=7 → FwdA=FwdB=1.
- XZR and Use gating: issue Rd=31, then Rn=31 → FwdA=0. Issue Rd=3 with UseRm=0 and Rm=3 → FwdB=0.
- Load-use: issue LDUR Rd=9, then Rn=9 → stall=1 for one cycle and stall_cnt=1. The next cycle gives stall=0 and FwdA=2. The same pattern with flush=1 gives stall=0, and the flushed instruction never matches later.
- Counter: force 70000 consecutive load-use stalls with CNT_W=16 → stall_cnt saturates at 65535. Assert reset mid-stall → counter and slots clear the same cycle.
